protocol_resp: RTL and testbench

//  Response-packet transmitter: the sending end of the sensor request/response byte protocol.

---
 rtl/protocol_pkg.sv | 29 ++
 rtl/protocol_resp_chk.sv | 26 ++
 rtl/protocol_resp.sv | 163 ++++++++++++++++
 tb/tb_protocol_resp.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/protocol_pkg.sv
// Shared constants for the sensor request/response byte protocol.
package protocol_pkg;

  localparam logic [7:0] SYNC_BYTE   = 8'hFF;
  localparam logic [7:0] FOOTER_BYTE = 8'h7F;

  localparam logic [7:0] RESP_OK  = 8'h00;
  localparam logic [7:0] RESP_ERR = 8'hFE;

  // 3-bit state codes, common to the request receiver and response transmitter
  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_SYNC   = 3'd1;
  localparam logic [2:0] ST_HEADER = 3'd2;
  localparam logic [2:0] ST_ADDR   = 3'd3;
  localparam logic [2:0] ST_DATA   = 3'd4;
  localparam logic [2:0] ST_CHK    = 3'd5;
  localparam logic [2:0] ST_FOOTER = 3'd6;

  typedef enum logic [2:0] {
    S_IDLE   = ST_IDLE,
    S_SYNC   = ST_SYNC,
    S_HEADER = ST_HEADER,
    S_ADDR   = ST_ADDR,
    S_DATA   = ST_DATA,
    S_CHK    = ST_CHK,
    S_FOOTER = ST_FOOTER
  } state_e;

endpackage

// File: rtl/protocol_resp_chk.sv
// Running XOR accumulator for the response checksum byte.
module protocol_resp_chk (
  input  logic       clk,
  input  logic       reset,
  input  logic       clr_i,
  input  logic       en_i,
  input  logic [7:0] byte_i,
  output logic [7:0] sum_o
);

  logic [7:0] acc_q;

  // Clear at packet start, fold in each accepted byte
  always_ff @(posedge clk) begin
    if (!reset) begin
      acc_q <= 8'h00;
    end else if (clr_i) begin
      acc_q <= 8'h00;
    end else if (en_i) begin
      acc_q <= acc_q ^ byte_i;
    end
  end

  assign sum_o = acc_q;

endmodule

// File: rtl/protocol_resp.sv
// Response-packet transmitter: latches a response on send and streams
// FF, header, address, data (MS byte first), [checksum], 7F over valid/ready.
// Optional checksum byte enabled by defining PROTOCOL_RESP_CHECKSUM_EN.
module protocol_resp
  import protocol_pkg::*;
#(
  parameter int unsigned DATA_BYTES = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    send,
  input  logic [7:0]              resp_code,
  input  logic [7:0]              sensor_addr,
  input  logic [8*DATA_BYTES-1:0] data,
  output logic [7:0]              out,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    busy,
  output logic                    done
);

  localparam int unsigned DW       = 8 * DATA_BYTES;
  localparam logic [2:0]  IDX_LAST = 3'(DATA_BYTES - 1);

  state_e          state_q;
  logic [7:0]      code_q;
  logic [7:0]      addr_q;
  logic [DW-1:0]   data_q;
  logic [2:0]      idx_q;
  logic [7:0]      out_q;
  logic            valid_q;
  logic            busy_q;
  logic            done_q;

  logic            xfer_c;
  logic [2:0]      idx_d;
  logic [2:0]      sel_idx_d;
  logic [63:0]     data_ext_d;
  logic [7:0]      data_byte_d;

  // Byte accepted downstream this cycle
  assign xfer_c = valid_q & out_ready;

  // Next payload byte: first (MS) byte when leaving ADDR, else one index lower
  assign idx_d       = idx_q - 3'd1;
  assign sel_idx_d   = (state_q == S_ADDR) ? IDX_LAST : idx_d;
  assign data_ext_d  = 64'(data_q);
  assign data_byte_d = data_ext_d[{sel_idx_d, 3'b000} +: 8];

`ifdef PROTOCOL_RESP_CHECKSUM_EN
  logic       chk_clr;
  logic       chk_en;
  logic [7:0] chk_sum;

  // Accumulate header, address and data bytes as they are accepted
  assign chk_clr = (state_q == S_IDLE) && send;
  assign chk_en  = xfer_c && ((state_q == S_HEADER) || (state_q == S_ADDR) ||
                              (state_q == S_DATA));

  protocol_resp_chk u_chk (
    .clk    (clk),
    .reset  (reset),
    .clr_i  (chk_clr),
    .en_i   (chk_en),
    .byte_i (out_q),
    .sum_o  (chk_sum)
  );
`endif

  // Packet sequencer; out/out_valid/busy/done are loaded for the state being entered
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_IDLE;
      code_q  <= 8'h00;
      addr_q  <= 8'h00;
      data_q  <= '0;
      idx_q   <= 3'd0;
      out_q   <= 8'h00;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (send) begin
            code_q  <= resp_code;
            addr_q  <= sensor_addr;
            data_q  <= data;
            state_q <= S_SYNC;
            out_q   <= SYNC_BYTE;
            valid_q <= 1'b1;
            busy_q  <= 1'b1;
          end
        end
        S_SYNC: begin
          if (xfer_c) begin
            state_q <= S_HEADER;
            out_q   <= code_q;
          end
        end
        S_HEADER: begin
          if (xfer_c) begin
            state_q <= S_ADDR;
            out_q   <= addr_q;
          end
        end
        S_ADDR: begin
          if (xfer_c) begin
            state_q <= S_DATA;
            idx_q   <= IDX_LAST;
            out_q   <= data_byte_d;
          end
        end
        S_DATA: begin
          if (xfer_c) begin
            if (idx_q == 3'd0) begin
`ifdef PROTOCOL_RESP_CHECKSUM_EN
              state_q <= S_CHK;
              out_q   <= chk_sum ^ out_q;
`else
              state_q <= S_FOOTER;
              out_q   <= FOOTER_BYTE;
`endif
            end else begin
              idx_q <= idx_d;
              out_q <= data_byte_d;
            end
          end
        end
`ifdef PROTOCOL_RESP_CHECKSUM_EN
        S_CHK: begin
          if (xfer_c) begin
            state_q <= S_FOOTER;
            out_q   <= FOOTER_BYTE;
          end
        end
`endif
        S_FOOTER: begin
          if (xfer_c) begin
            state_q <= S_IDLE;
            out_q   <= 8'h00;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        default: begin
          state_q <= S_IDLE;
          out_q   <= 8'h00;
          valid_q <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign out       = out_q;
  assign out_valid = valid_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_protocol_resp.sv
// Bench for protocol_resp: packet-queue model, per-cycle compare, literal packet checks.
module tb_protocol_resp;

  localparam int unsigned DB = 2;

  logic          clk;
  logic          reset;
  logic          send;
  logic [7:0]    resp_code;
  logic [7:0]    sensor_addr;
  logic [8*DB-1:0] data;
  logic [7:0]    out;
  logic          out_valid;
  logic          out_ready;
  logic          busy;
  logic          done;

  int checks = 0;
  int errors = 0;

  logic [7:0] mq[$];    // bytes the DUT still owes for the current packet
  logic [7:0] log_q[$]; // bytes actually handed over, for literal checks
  logic       exp_done = 1'b0;
  logic       live = 1'b0;

  protocol_resp #(.DATA_BYTES(DB)) dut (
    .clk         (clk),
    .reset       (reset),
    .send        (send),
    .resp_code   (resp_code),
    .sensor_addr (sensor_addr),
    .data        (data),
    .out         (out),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .busy        (busy),
    .done        (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Whole packet as the protocol defines it
  task automatic model_load(input logic [7:0] c, input logic [7:0] a, input logic [8*DB-1:0] d);
    logic [7:0] x;
    x = c ^ a;
    mq.push_back(8'hFF);
    mq.push_back(c);
    mq.push_back(a);
    for (int i = DB - 1; i >= 0; i--) begin
      mq.push_back(d[8*i +: 8]);
      x = x ^ d[8*i +: 8];
    end
`ifdef PROTOCOL_RESP_CHECKSUM_EN
    mq.push_back(x);
`endif
    mq.push_back(8'h7F);
  endtask

  // Model update on each active edge
  always @(posedge clk) begin
    live <= 1'b1;
    if (!reset) begin
      mq.delete();
      exp_done <= 1'b0;
    end else begin
      exp_done <= (mq.size() == 1) && out_ready;
      if (mq.size() != 0) begin
        if (out_ready) begin
          log_q.push_back(out);
          void'(mq.pop_front());
        end
      end else if (send) begin
        model_load(resp_code, sensor_addr, data);
      end
    end
  end

  // Per-cycle compare against the model
  always @(negedge clk) begin
    if (live) begin
      if (mq.size() != 0) begin
        check("out_valid", 32'(out_valid), 32'd1);
        check("out", 32'(out), 32'(mq[0]));
        check("busy", 32'(busy), 32'd1);
        check("done", 32'(done), 32'd0);
      end else begin
        check("idle_valid", 32'(out_valid), 32'd0);
        check("idle_out", 32'(out), 32'd0);
        check("idle_busy", 32'(busy), 32'd0);
        check("done", 32'(done), 32'(exp_done));
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  task automatic send_pkt(input logic [7:0] c, input logic [7:0] a, input logic [8*DB-1:0] d);
    resp_code   = c;
    sensor_addr = a;
    data        = d;
    send        = 1'b1;
    tick();
    send        = 1'b0;
  endtask

  task automatic wait_done(input string name);
    bit got;
    got = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (done) begin
        got = 1'b1;
        break;
      end
      tick();
    end
    check(name, 32'(got), 32'd1);
  endtask

  task automatic wait_out(input string name, input logic [7:0] b);
    bit got;
    got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (out_valid && out == b) begin
        got = 1'b1;
        break;
      end
      tick();
    end
    check(name, 32'(got), 32'd1);
  endtask

  task automatic check_pkt(input string name, input logic [63:0] exp, input int n);
    check({name, "_len"}, 32'(log_q.size()), 32'(n));
    for (int i = 0; i < n && i < log_q.size(); i++)
      check(name, 32'(log_q[i]), 32'(exp[8*(n-1-i) +: 8]));
  endtask

`ifdef PROTOCOL_RESP_CHECKSUM_EN
  localparam int PN = 7;
  localparam logic [63:0] P2 = 64'hFF010A12342D7F;
  localparam logic [63:0] P3 = 64'hFF020A55663B7F;
  localparam logic [63:0] P4 = 64'hFF030BABCD6E7F;
  localparam logic [63:0] P4B = 64'hFF040C01020B7F;
  localparam logic [63:0] P5 = 64'hFF060E33447F7F;
  localparam logic [63:0] P6 = 64'hFF070FFF7F887F;
`else
  localparam int PN = 6;
  localparam logic [63:0] P2 = 64'hFF010A12347F;
  localparam logic [63:0] P3 = 64'hFF020A55667F;
  localparam logic [63:0] P4 = 64'hFF030BABCD7F;
  localparam logic [63:0] P4B = 64'hFF040C01027F;
  localparam logic [63:0] P5 = 64'hFF060E33447F;
  localparam logic [63:0] P6 = 64'hFF070FFF7F7F;
`endif

  initial begin
    logic [63:0] lit;
    reset       = 1'b0;
    send        = 1'b1;
    resp_code   = 8'h99;
    sensor_addr = 8'h99;
    data        = 16'h9999;
    out_ready   = 1'b1;

    // 1. reset held with send asserted
    repeat (3) tick();
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_out", 32'(out), 32'd0);
    send  = 1'b0;
    reset = 1'b1;
    tick();

    // 2. basic packet, consecutive cycles, done right after footer
    log_q.delete();
    send_pkt(8'h01, 8'h0A, 16'h1234);
    lit = P2;
    for (int i = 0; i < PN; i++) begin
      @(negedge clk);
      check("seq_valid", 32'(out_valid), 32'd1);
      check("seq_byte", 32'(out), 32'(lit[8*(PN-1-i) +: 8]));
    end
    @(negedge clk);
    check("seq_done", 32'(done), 32'd1);
    check("seq_done_valid", 32'(out_valid), 32'd0);
    check_pkt("pkt_basic", P2, PN);

    // 3. backpressure while the address byte is on out
    tick();
    log_q.delete();
    send_pkt(8'h02, 8'h0A, 16'h5566);
    wait_out("bp_reach_addr", 8'h0A);
    out_ready = 1'b0;
    repeat (3) begin
      tick();
      check("bp_hold_out", 32'(out), 32'h0A);
      check("bp_hold_valid", 32'(out_valid), 32'd1);
    end
    out_ready = 1'b1;
    wait_done("bp_done");
    check_pkt("pkt_bp", P3, PN);

    // 4. send during ADDR ignored; send in done cycle starts next packet
    tick();
    log_q.delete();
    send_pkt(8'h03, 8'h0B, 16'hABCD);
    wait_out("ign_reach_addr", 8'h0B);
    send_pkt(8'hEE, 8'h55, 16'h9999);
    wait_done("ign_done");
    check_pkt("pkt_ignore", P4, PN);
    log_q.delete();
    send_pkt(8'h04, 8'h0C, 16'h0102);
    check("b2b_sync", 32'(out), 32'hFF);
    check("b2b_valid", 32'(out_valid), 32'd1);
    wait_done("b2b_done");
    check_pkt("pkt_b2b", P4B, PN);

    // 5. reset in DATA aborts silently
    tick();
    send_pkt(8'h05, 8'h0D, 16'h1122);
    wait_out("abort_reach_data", 8'h11);
    reset = 1'b0;
    tick();
    check("abort_valid", 32'(out_valid), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_out", 32'(out), 32'd0);
    reset = 1'b1;
    repeat (3) begin
      tick();
      check("abort_no_done", 32'(done), 32'd0);
    end
    log_q.delete();
    send_pkt(8'h06, 8'h0E, 16'h3344);
    wait_done("post_abort_done");
    check_pkt("pkt_post_abort", P5, PN);

    // 6. payload bytes equal to sync/footer go out verbatim
    tick();
    log_q.delete();
    send_pkt(8'h07, 8'h0F, 16'hFF7F);
    wait_done("verb_done");
    check_pkt("pkt_verbatim", P6, PN);

    repeat (3) tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
